// File: rtl/id_ctrl.sv
// Instruction-decode slot controller: single-entry ID buffer with a register
// scoreboard for RAW hazards, flush handling and a saturating stall counter.
module id_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_valid_i,
  input  logic [31:0] if_instr_i,
  input  logic [31:0] if_pc_i,
  output logic        if_ready_o,
  input  logic [4:0]  dec_rs1_i,
  input  logic [4:0]  dec_rs2_i,
  input  logic        dec_use_rs1_i,
  input  logic        dec_use_rs2_i,
  input  logic [4:0]  dec_rd_i,
  input  logic        dec_we_i,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic        issue_valid_o,
  input  logic        ex_ready_i,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  input  logic        flush_i,
  output logic [15:0] stall_cnt_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_FULL  = 2'b01,
    S_STALL = 2'b10
  } state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [15:0] stall_q, stall_d;

  logic [31:0] pend_eff;
  logic        held, hazard, issue_valid, fire, if_ready, accept;

  // A retiring writeback releases its register in the same cycle it is checked.
  always_comb begin
    pend_eff = pend_q;
    if (wb_valid_i) pend_eff[wb_rd_i] = 1'b0;
    hazard = (dec_use_rs1_i & pend_eff[dec_rs1_i]) |
             (dec_use_rs2_i & pend_eff[dec_rs2_i]);
  end

  assign held        = (state_q == S_FULL) || (state_q == S_STALL);
  assign issue_valid = rst_i & held & ~hazard & ~flush_i;
  assign fire        = issue_valid & ex_ready_i;
  assign if_ready    = rst_i & ((state_q == S_EMPTY) | fire);
  assign accept      = if_valid_i & if_ready & ~flush_i;

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;

    unique case (state_q)
      S_EMPTY: begin
        if (accept) state_d = S_FULL;
      end
      S_FULL, S_STALL: begin
        if (fire) state_d = accept ? S_FULL : S_EMPTY;
        else      state_d = S_STALL;
      end
      default: state_d = S_EMPTY;
    endcase

    if (accept) begin
      instr_d = if_instr_i;
      pc_d    = if_pc_i;
    end else if (fire) begin
      instr_d = NOP;
    end

    // Flush drops both the held word and any offer; the PC keeps its last value.
    if (flush_i) begin
      state_d = S_EMPTY;
      instr_d = NOP;
      pc_d    = pc_q;
    end
  end

  // Set from issue is applied after the writeback clear, so set wins.
  always_comb begin
    pend_d = pend_q;
    if (wb_valid_i) pend_d[wb_rd_i] = 1'b0;
    if (fire && dec_we_i && (dec_rd_i != 5'd0)) pend_d[dec_rd_i] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_comb begin
    stall_d = stall_q;
    if (held && !fire && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_EMPTY;
      instr_q <= NOP;
      pc_q    <= '0;
      pend_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      stall_q <= stall_d;
    end
  end

  assign if_ready_o    = if_ready;
  assign issue_valid_o = issue_valid;
  assign id_instr_o    = instr_q;
  assign id_pc_o       = pc_q;
  assign stall_cnt_o   = stall_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_id_ctrl.sv
// Directed bench for id_ctrl: issued words are checked by a monitor against a
// queue of expected {instr, pc}; state/counter checks are made inline.
module tb_id_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_valid_i;
  logic [31:0] if_instr_i;
  logic [31:0] if_pc_i;
  logic        if_ready_o;
  logic [4:0]  dec_rs1_i, dec_rs2_i, dec_rd_i;
  logic        dec_use_rs1_i, dec_use_rs2_i, dec_we_i;
  logic [31:0] id_instr_o, id_pc_o;
  logic        issue_valid_o;
  logic        ex_ready_i;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic        flush_i;
  logic [15:0] stall_cnt_o;
  logic [1:0]  state_o;

  always #5 clk_i = ~clk_i;

  id_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_valid_i(if_valid_i), .if_instr_i(if_instr_i), .if_pc_i(if_pc_i),
    .if_ready_o(if_ready_o),
    .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i),
    .dec_use_rs1_i(dec_use_rs1_i), .dec_use_rs2_i(dec_use_rs2_i),
    .dec_rd_i(dec_rd_i), .dec_we_i(dec_we_i),
    .id_instr_o(id_instr_o), .id_pc_o(id_pc_o),
    .issue_valid_o(issue_valid_o), .ex_ready_i(ex_ready_i),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
    .flush_i(flush_i), .stall_cnt_o(stall_cnt_o), .state_o(state_o)
  );

  // Minimal RV32 decoder stub for OP-IMM, LOAD and OP.
  always_comb begin
    dec_rs1_i     = id_instr_o[19:15];
    dec_rs2_i     = id_instr_o[24:20];
    dec_rd_i      = id_instr_o[11:7];
    dec_use_rs1_i = (id_instr_o[6:0] == 7'h13) || (id_instr_o[6:0] == 7'h03) ||
                    (id_instr_o[6:0] == 7'h33);
    dec_use_rs2_i = (id_instr_o[6:0] == 7'h33);
    dec_we_i      = dec_use_rs1_i;
  end

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [1:0] ST_EMPTY = 2'b00, ST_FULL = 2'b01, ST_STALL = 2'b10;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;
  logic [63:0] exp_q[$];

  function automatic logic [31:0] enc_addi(logic [4:0] rd, logic [4:0] rs1, logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'h13};
  endfunction
  function automatic logic [31:0] enc_lw(logic [4:0] rd, logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, 7'h03};
  endfunction
  function automatic logic [31:0] enc_add(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_i === 1'b1 && issue_valid_o === 1'b1 && ex_ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected issue pc", id_pc_o, 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("issue instr", id_instr_o, e[63:32]);
        chk("issue pc", id_pc_o, e[31:0]);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b0; if_valid_i = 1'b0; flush_i = 1'b0; wb_valid_i = 1'b0;
    wb_rd_i = '0; ex_ready_i = 1'b1; if_instr_i = '0; if_pc_i = '0;
    @(negedge clk_i);
    chk("rst if_ready", {31'd0, if_ready_o}, 32'd0);
    chk("rst issue_valid", {31'd0, issue_valid_o}, 32'd0);
    step();
    @(negedge clk_i);
    chk("rst state", {30'd0, state_o}, 32'd0);
    chk("rst instr", id_instr_o, NOP);
    chk("rst pc", id_pc_o, 32'd0);
    chk("rst stall_cnt", {16'd0, stall_cnt_o}, 32'd0);
    step();
    rst_i = 1'b1;
  endtask

  // Offers a word until accepted; returns the number of cycles it took.
  task automatic offer(input logic [31:0] instr, input logic [31:0] pc,
                       input bit push, output int n);
    logic rdy;
    if_valid_i = 1'b1; if_instr_i = instr; if_pc_i = pc;
    n = 0;
    do begin
      @(negedge clk_i);
      rdy = if_ready_o;
      step();
      n++;
    end while (!rdy && n < 100);
    if (!rdy) chk("offer timeout pc", pc, 32'hFFFF_FFFF);
    else if (push) exp_q.push_back({instr, pc});
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_i = 1'b1; if_valid_i = 1'b0; flush_i = 1'b0; wb_valid_i = 1'b0;
    wb_rd_i = '0; ex_ready_i = 1'b1; if_instr_i = '0; if_pc_i = '0;

    // Back-to-back ADDI x1
    do_reset();
    for (int unsigned i = 0; i < 3; i++) begin
      offer(enc_addi(5'd1, 5'd0, 12'd1), 32'(i * 4), 1'b1, n);
      if (i > 0) chk("b2b accept cycles", n, 32'd1);
    end
    if_valid_i = 1'b0;
    @(negedge clk_i);
    chk("b2b last held", {30'd0, state_o}, {30'd0, ST_FULL});
    step();
    @(negedge clk_i);
    chk("b2b state", {30'd0, state_o}, {30'd0, ST_EMPTY});
    chk("b2b empty nop", id_instr_o, NOP);
    chk("b2b pc hold", id_pc_o, 32'h8);
    chk("b2b stall_cnt", {16'd0, stall_cnt_o}, 32'd0);

    // RAW on x5
    do_reset();
    offer(enc_lw(5'd5, 5'd0), 32'h100, 1'b1, n);
    offer(enc_add(5'd6, 5'd5, 5'd5), 32'h104, 1'b1, n);
    if_valid_i = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("raw issue_valid", {31'd0, issue_valid_o}, 32'd0);
      chk("raw state", {30'd0, state_o}, (i == 0) ? {30'd0, ST_FULL} : {30'd0, ST_STALL});
      chk("raw held instr", id_instr_o, enc_add(5'd6, 5'd5, 5'd5));
      chk("raw held pc", id_pc_o, 32'h104);
      step();
    end
    wb_valid_i = 1'b1; wb_rd_i = 5'd5;
    @(negedge clk_i);
    chk("raw wb issue", {31'd0, issue_valid_o}, 32'd1);
    step();
    wb_valid_i = 1'b0;
    @(negedge clk_i);
    chk("raw stall_cnt", {16'd0, stall_cnt_o}, 32'd3);
    chk("raw after state", {30'd0, state_o}, {30'd0, ST_EMPTY});

    // Same-cycle set/clear on x7
    do_reset();
    offer(enc_addi(5'd7, 5'd0, 12'd1), 32'h10, 1'b1, n);
    offer(enc_addi(5'd7, 5'd0, 12'd2), 32'h14, 1'b1, n);
    if_valid_i = 1'b0;
    wb_valid_i = 1'b1; wb_rd_i = 5'd7;
    @(negedge clk_i);
    chk("setclr issue", {31'd0, issue_valid_o}, 32'd1);
    step();
    wb_valid_i = 1'b0;
    offer(enc_add(5'd8, 5'd7, 5'd0), 32'h18, 1'b1, n);
    if_valid_i = 1'b0;
    @(negedge clk_i);
    chk("setclr set wins", {31'd0, issue_valid_o}, 32'd0);
    step();
    wb_valid_i = 1'b1; wb_rd_i = 5'd7;
    @(negedge clk_i);
    chk("setclr release", {31'd0, issue_valid_o}, 32'd1);
    step();
    wb_valid_i = 1'b0;

    // Flush while stalled, then flush while empty
    do_reset();
    offer(enc_lw(5'd9, 5'd0), 32'h200, 1'b1, n);
    offer(enc_add(5'd10, 5'd9, 5'd9), 32'h204, 1'b0, n);
    if_valid_i = 1'b0;
    step();
    flush_i = 1'b1; if_valid_i = 1'b1;
    if_instr_i = enc_addi(5'd11, 5'd0, 12'd1); if_pc_i = 32'h40;
    @(negedge clk_i);
    chk("flush pre state", {30'd0, state_o}, {30'd0, ST_STALL});
    chk("flush no issue", {31'd0, issue_valid_o}, 32'd0);
    step();
    flush_i = 1'b0; if_valid_i = 1'b0;
    @(negedge clk_i);
    chk("flush state", {30'd0, state_o}, {30'd0, ST_EMPTY});
    chk("flush nop", id_instr_o, NOP);
    chk("flush pc dropped", id_pc_o, 32'h204);
    flush_i = 1'b1; if_valid_i = 1'b1;
    #1;
    chk("flush empty if_ready", {31'd0, if_ready_o}, 32'd1);
    step();
    flush_i = 1'b0; if_valid_i = 1'b0;
    @(negedge clk_i);
    chk("flush empty offer dropped", {30'd0, state_o}, {30'd0, ST_EMPTY});
    step();
    offer(enc_add(5'd12, 5'd9, 5'd0), 32'h208, 1'b1, n);
    if_valid_i = 1'b0;
    @(negedge clk_i);
    chk("flush pending kept", {31'd0, issue_valid_o}, 32'd0);
    step();
    wb_valid_i = 1'b1; wb_rd_i = 5'd9;
    step();
    wb_valid_i = 1'b0;
    @(negedge clk_i);
    chk("flush stall_cnt", {16'd0, stall_cnt_o}, 32'd3);

    // x0 is never pending
    do_reset();
    offer(enc_addi(5'd0, 5'd0, 12'd5), 32'h300, 1'b1, n);
    offer(enc_add(5'd13, 5'd0, 5'd0), 32'h304, 1'b1, n);
    chk("x0 accept cycles", n, 32'd1);
    if_valid_i = 1'b0;
    @(negedge clk_i);
    chk("x0 reader issues", {31'd0, issue_valid_o}, 32'd1);
    step();
    @(negedge clk_i);
    chk("x0 stall_cnt", {16'd0, stall_cnt_o}, 32'd0);

    // Stall counter saturation with EX back-pressure
    do_reset();
    ex_ready_i = 1'b0;
    offer(enc_addi(5'd1, 5'd0, 12'd1), 32'h400, 1'b1, n);
    if_valid_i = 1'b0;
    repeat (65534) @(posedge clk_i);
    #1;
    chk("sat 0xFFFE", {16'd0, stall_cnt_o}, 32'h0000_FFFE);
    repeat (4466) @(posedge clk_i);
    #1;
    chk("sat 0xFFFF", {16'd0, stall_cnt_o}, 32'h0000_FFFF);
    chk("sat held pc", id_pc_o, 32'h400);
    ex_ready_i = 1'b1;
    step();
    @(negedge clk_i);
    chk("sat after fire", {16'd0, stall_cnt_o}, 32'h0000_FFFF);

    // Reset pulse mid-stall
    do_reset();
    offer(enc_lw(5'd5, 5'd0), 32'h500, 1'b1, n);
    offer(enc_add(5'd6, 5'd5, 5'd5), 32'h504, 1'b0, n);
    if_valid_i = 1'b0;
    step();
    rst_i = 1'b0; if_valid_i = 1'b1;
    if_instr_i = enc_addi(5'd2, 5'd0, 12'd1); if_pc_i = 32'h508;
    @(negedge clk_i);
    chk("midrst if_ready", {31'd0, if_ready_o}, 32'd0);
    chk("midrst issue_valid", {31'd0, issue_valid_o}, 32'd0);
    step();
    rst_i = 1'b1; if_valid_i = 1'b0;
    @(negedge clk_i);
    chk("midrst state", {30'd0, state_o}, 32'd0);
    chk("midrst stall_cnt", {16'd0, stall_cnt_o}, 32'd0);
    chk("midrst instr", id_instr_o, NOP);
    chk("midrst pc", id_pc_o, 32'd0);
    chk("midrst if_ready after", {31'd0, if_ready_o}, 32'd1);
    step();
    offer(enc_add(5'd14, 5'd5, 5'd0), 32'h50C, 1'b1, n);
    if_valid_i = 1'b0;
    @(negedge clk_i);
    chk("midrst pending cleared", {31'd0, issue_valid_o}, 32'd1);
    repeat (3) step();

    chk("expected queue drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/id_ctrl.md
ID_CTRL -- requirements
Module: id_ctrl

Interface
REQ-001 SHALL have ports: clk_i  in  1  sole clock, rising edge.
REQ-002 SHALL have: rst_i  in  1  reset, synchronous, active-low.
REQ-003 SHALL have: if_valid_i  in  1  fetch offers instruction; if_instr_i  in  32  fetched word; if_pc_i  in  32  its PC.
REQ-004 SHALL have: if_ready_o  out  1  ID slot accepts the offer this cycle.
REQ-005 SHALL have: dec_rs1_i, dec_rs2_i  in  5 each  source regs from the combinational decoder; dec_use_rs1_i, dec_use_rs2_i  in  1 each  source is read; dec_rd_i  in  5; dec_we_i  in  1  instruction writes rd.
REQ-006 SHALL have: id_instr_o  out  32  held word, drives the decoder; id_pc_o  out  32  held PC.
REQ-007 SHALL have: issue_valid_o  out  1  held instruction issues to EX; ex_ready_i  in  1  EX accepts.
REQ-008 SHALL have: wb_valid_i  in  1  writeback retires; wb_rd_i  in  5  retired rd.
REQ-009 SHALL have: flush_i  in  1  redirect (taken branch/jump); stall_cnt_o  out  16  saturating stall-cycle counter; state_o  out  2  FSM state.

Function
REQ-010 SHALL implement FSM EMPTY(2'b00), FULL(2'b01), STALL(2'b10).
REQ-011 SHALL assert if_ready_o when state is EMPTY, or when state is FULL/STALL and issue fires this cycle.
REQ-012 Accept: if_valid_i & if_ready_o & !flush_i captures if_instr_i/if_pc_i into the slot at the next edge.
REQ-013 Scoreboard: 32-bit pending vector; bit 0 SHALL always read 0.
REQ-014 Hazard = (dec_use_rs1_i & pend_eff[dec_rs1_i]) | (dec_use_rs2_i & pend_eff[dec_rs2_i]); pend_eff = pending with bit wb_rd_i cleared when wb_valid_i (same-cycle writeback resolves hazard).
REQ-015 issue_valid_o SHALL be 1 iff state is FULL or STALL, !hazard, !flush_i.
REQ-016 Issue fires on issue_valid_o & ex_ready_i; on fire with dec_we_i & dec_rd_i!=0, pending[dec_rd_i] SHALL be set.
REQ-017 wb_valid_i SHALL clear pending[wb_rd_i]; if the same register is set by an issue in the same cycle, set wins.
REQ-018 Transitions: EMPTY->FULL on accept; FULL/STALL->FULL on fire with accept; FULL/STALL->EMPTY on fire without accept; FULL->STALL when held and no fire due to hazard or !ex_ready_i; STALL->FULL never without fire.
REQ-019 flush_i SHALL, at the next edge, force EMPTY, discard the held word and any same-cycle offer; if_ready_o stays as per REQ-011; pending SHALL NOT be cleared (in-flight writes still retire).
REQ-020 Held word and PC SHALL remain stable while not fired (no change in STALL).
REQ-021 stall_cnt_o SHALL increment each cycle state is FULL or STALL with no fire, saturating at 16'hFFFF.
REQ-022 Latency: accepted word visible on id_instr_o the cycle after accept; earliest issue same cycle it becomes visible.
REQ-023 In EMPTY, id_instr_o SHALL be 32'h00000013 (NOP) and id_pc_o SHALL hold its last value.

Reset
REQ-024 When rst_i=0 at an edge: state EMPTY, pending all 0, stall_cnt_o 0, id_instr_o 32'h00000013, id_pc_o 0.
REQ-025 During reset cycles if_ready_o and issue_valid_o SHALL be 0; reset mid-stall SHALL abandon the held word.

Verification
REQ-026 Back-to-back: offer ADDI x1 at PC 0x0, 0x4, 0x8 with ex_ready_i=1, no hazards -> one issue per cycle, stall_cnt_o=0.
REQ-027 RAW: issue LW x5 (we, rd=5), next instr ADD x6,x5,x5 -> STALL, issue_valid_o=0 until wb_valid_i with wb_rd_i=5, issue same cycle, stall_cnt_o equals stall cycles.
REQ-028 Same-cycle set/clear: wb retires x7 while issuing new write to x7 -> pending[7]=1 after edge.
REQ-029 Flush while STALL with fetch offering PC 0x40 -> next cycle EMPTY, NOP on id_instr_o, PC 0x40 word dropped, pending unchanged.
REQ-030 Write to x0 issued, then reader of x0 -> no stall; stall_cnt_o saturates at 0xFFFF under 70000 forced ex_ready_i=0 cycles.
REQ-031 rst_i=0 pulsed mid-STALL -> all REQ-024 values next cycle, if_ready_o=1 once rst_i=1.
